// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
//   Shared types and constants for the iterative multiply/divide unit:
//   FSM state encoding, iteration counts and the radix-4 Booth digit set,
//   plus the Booth recoding helper used by booth_sel.
// -----------------------------------------------------------------------------
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned MULT_ITERS = 16;  // 2 multiplier bits per cycle
    localparam int unsigned DIV_ITERS  = 32;  // 1 quotient bit per cycle
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_e;

    // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_e booth_decode(input logic [2:0] bits);
        booth_e digit;
        case (bits)
            3'b001, 3'b010: digit = BOOTH_POS1;
            3'b011:         digit = BOOTH_POS2;
            3'b100:         digit = BOOTH_NEG2;
            3'b101, 3'b110: digit = BOOTH_NEG1;
            default:        digit = BOOTH_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_sel.sv
// -----------------------------------------------------------------------------
// booth_sel
//   Recodes three multiplier bits into one radix-4 Booth partial product
//   (0, +/-M, +/-2M), sign-extended two bits beyond the multiplicand so that
//   +/-2M of the most negative multiplicand still fits.
// Ports
//   bits   in  3        {b[2i+1], b[2i], b[2i-1]}
//   mcand  in  WIDTH    signed multiplicand M
//   pp     out WIDTH+2  selected signed partial product
// -----------------------------------------------------------------------------
module booth_sel
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    logic [WIDTH+1:0] m_ext;
    booth_e           digit;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        pp    = '0;
        m_ext = {{2{mcand[WIDTH-1]}}, mcand};
        digit = booth_decode(bits);
        case (digit)
            BOOTH_POS1: pp = m_ext;
            BOOTH_POS2: pp = m_ext << 1;
            BOOTH_NEG1: pp = -m_ext;
            BOOTH_NEG2: pp = -(m_ext << 1);
            default:    pp = '0;
        endcase
    end

endmodule

// File: rtl/multdiv_iterative.sv
// -----------------------------------------------------------------------------
// multdiv_iterative
//   Iterative signed 32-bit multiply / divide unit for the execute stage.
//   MULT: radix-4 Booth, 16 cycles. DIV: non-restoring on magnitudes, 32 cycles.
//   A start pulse samples the operands; data_resultRDY pulses for one cycle
//   in DONE, when data_result / data_exception (and data_resultHi) are valid.
//   A start in any state aborts the running operation and restarts.
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-low
//   ctrl_MULT       in   start multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   start divide
//   data_operandA   in   multiplicand / dividend (signed)
//   data_operandB   in   multiplier / divisor (signed)
//   data_result     out  low product word / quotient
//   data_exception  out  signed overflow or divide-by-zero
//   data_resultRDY  out  one-cycle result-valid pulse
//   data_resultHi   out  only with MULTDIV_HI_EN: P[63:32] / remainder / 0 on divide-by-zero
// Configuration
//   MULTDIV_HI_EN   define to add data_resultHi
// Datapath
//   acc_q holds {hi[WIDTH+1:0], lo[WIDTH-1:0]}:
//     MULT: hi = running partial-product sum, lo = unconsumed multiplier bits
//           (product bits shift in from the top as the multiplier shifts out).
//     DIV:  hi = signed partial remainder, lo = dividend bits / quotient bits.
// -----------------------------------------------------------------------------
module multdiv_iterative
    import multdiv_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter logic [WIDTH-1:0] DIV_BY_ZERO_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef MULTDIV_HI_EN
    ,
    output logic [WIDTH-1:0] data_resultHi
`endif
);

    localparam int HW = WIDTH + 2;   // hi half of the accumulator
    localparam int AW = WIDTH + HW;  // full accumulator

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;      // M for MULT, |B| for DIV
    logic               booth_prev_q, booth_prev_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
`ifdef MULTDIV_HI_EN
    logic [WIDTH-1:0]   hi_q, hi_d;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [HW-1:0]    pp;
    logic [HW-1:0]    hi_sum, div_ext, rem_sh, rem_new;
    logic [AW-1:0]    mult_next, div_next;
    logic [WIDTH-1:0] abs_a, abs_b, q_mag, quotient;
    logic             q_neg, mult_ovf, div_zero;

    booth_sel #(.WIDTH(WIDTH)) u_booth_sel (
        .bits  ({acc_q[1], acc_q[0], booth_prev_q}),
        .mcand (mcand_q),
        .pp    (pp)
    );

    always_comb begin
        abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

        // Booth step: add the partial product to the hi half, then shift the
        // whole accumulator right arithmetically by one radix-4 digit.
        hi_sum    = acc_q[AW-1:WIDTH] + pp;
        mult_next = {{2{hi_sum[HW-1]}}, hi_sum, acc_q[WIDTH-1:2]};
        // After the last step acc holds P; overflow unless P[63:31] is a pure sign run.
        mult_ovf  = !((&mult_next[2*WIDTH-1:WIDTH-1]) || !(|mult_next[2*WIDTH-1:WIDTH-1]));

        // Non-restoring step: shift the next dividend bit into the remainder,
        // subtract the divisor if the remainder is non-negative, else add it.
        div_ext  = {2'b00, mcand_q};
        rem_sh   = {acc_q[AW-2:WIDTH], acc_q[WIDTH-1]};
        rem_new  = acc_q[AW-1] ? rem_sh + div_ext : rem_sh - div_ext;
        div_next = {rem_new, acc_q[WIDTH-2:0], ~rem_new[HW-1]};

        q_mag    = div_next[WIDTH-1:0];
        q_neg    = a_neg_q ^ b_neg_q;
        quotient = q_neg ? -q_mag : q_mag;
        div_zero = (mcand_q == '0);
    end

`ifdef MULTDIV_HI_EN
    logic [WIDTH-1:0] rem_fix, rem_signed;

    // The last non-restoring step can leave a negative remainder; one
    // corrective add restores it. The remainder takes the dividend's sign.
    always_comb begin
        rem_fix    = rem_new[HW-1] ? WIDTH'(rem_new + div_ext) : rem_new[WIDTH-1:0];
        rem_signed = a_neg_q ? -rem_fix : rem_fix;
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        booth_prev_d = booth_prev_q;
        a_neg_d      = a_neg_q;
        b_neg_d      = b_neg_q;
        result_d     = result_q;
        exc_d        = exc_q;
`ifdef MULTDIV_HI_EN
        hi_d         = hi_q;
`endif

        // A start in any state restarts; the aborted op never reaches DONE.
        if (ctrl_MULT) begin
            state_d      = ST_MULT;
            cnt_d        = '0;
            acc_d        = {{HW{1'b0}}, data_operandB};
            mcand_d      = data_operandA;
            booth_prev_d = 1'b0;
        end else if (ctrl_DIV) begin
            state_d = ST_DIV;
            cnt_d   = '0;
            acc_d   = {{HW{1'b0}}, abs_a};
            mcand_d = abs_b;
            a_neg_d = data_operandA[WIDTH-1];
            b_neg_d = data_operandB[WIDTH-1];
        end else begin
            case (state_q)
                ST_IDLE: ;

                ST_MULT: begin
                    acc_d        = mult_next;
                    booth_prev_d = acc_q[1];
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MULT_ITERS - 1)) begin
                        state_d  = ST_DONE;
                        result_d = mult_next[WIDTH-1:0];
                        exc_d    = mult_ovf;
`ifdef MULTDIV_HI_EN
                        hi_d     = mult_next[2*WIDTH-1:WIDTH];
`endif
                    end
                end

                ST_DIV: begin
                    if (div_zero) begin
                        state_d  = ST_DONE;
                        result_d = DIV_BY_ZERO_VAL;
                        exc_d    = 1'b1;
`ifdef MULTDIV_HI_EN
                        hi_d     = '0;
`endif
                    end else begin
                        acc_d = div_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                            state_d  = ST_DONE;
                            result_d = quotient;
                            // Only MIN_INT / -1 yields a positive quotient of 2^31.
                            exc_d    = !q_neg && q_mag[WIDTH-1];
`ifdef MULTDIV_HI_EN
                            hi_d     = rem_signed;
`endif
                        end
                    end
                end

                ST_DONE: state_d = ST_IDLE;

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            booth_prev_q <= 1'b0;
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            result_q     <= '0;
            exc_q        <= 1'b0;
`ifdef MULTDIV_HI_EN
            hi_q         <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            booth_prev_q <= booth_prev_d;
            a_neg_q      <= a_neg_d;
            b_neg_q      <= b_neg_d;
            result_q     <= result_d;
            exc_q        <= exc_d;
`ifdef MULTDIV_HI_EN
            hi_q         <= hi_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);
`ifdef MULTDIV_HI_EN
    assign data_resultHi  = hi_q;
`endif

endmodule

// File: tb/tb_multdiv_iterative.sv
// -----------------------------------------------------------------------------
// tb_multdiv_iterative
//   Directed and randomized checks of multdiv_iterative against a plain
//   arithmetic reference (64-bit product, SV integer divide / modulo).
//   Latency is counted in rising edges after the start edge k: a result that
//   the pipeline samples in cycle k+17 is visible just after edge k+16.
// -----------------------------------------------------------------------------
module tb_multdiv_iterative;

    localparam logic [31:0] DBZ = 32'h0BAD_D1D0;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef MULTDIV_HI_EN
    logic [31:0] data_resultHi;
`endif

    int tests;
    int fails;

    multdiv_iterative #(.WIDTH(32), .DIV_BY_ZERO_VAL(DBZ)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
`ifdef MULTDIV_HI_EN
        ,
        .data_resultHi  (data_resultHi)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the arithmetic rules.
    task automatic ref_model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic e, output logic [31:0] hi,
                             output int lat);
        longint      p;
        logic [63:0] pv;
        int          sa;
        int          sb;
        longint      max32;
        longint      min32;
        sa    = $signed(a);
        sb    = $signed(b);
        max32 = 64'sh0000_0000_7FFF_FFFF;
        min32 = -64'sh0000_0000_8000_0000;
        if (is_mult) begin
            p   = longint'(sa) * longint'(sb);
            pv  = p;
            r   = pv[31:0];
            hi  = pv[63:32];
            e   = (p > max32) || (p < min32);
            lat = 16;
        end else if (b == 32'h0) begin
            r   = DBZ;
            e   = 1'b1;
            hi  = 32'h0;
            lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = 32'h8000_0000;
            e   = 1'b1;
            hi  = 32'h0;
            lat = 32;
        end else begin
            r   = sa / sb;
            hi  = sa % sb;
            e   = 1'b0;
            lat = 32;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] ext [5];
        logic [31:0] v;
        ext = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 40)) - 32'd20;
            2:       v = {{16{1'b0}}, 16'($urandom)} - 32'h0000_8000;
            default: v = ext[$urandom_range(0, 4)];
        endcase
        return v;
    endfunction

    // One start pulse, wait for RDY (bounded), check values, then check the
    // pulse is one cycle wide and the outputs hold.
    task automatic run_op(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e,
                          input logic [31:0] exp_hi, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);  // edge k
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;  // must not disturb the running op
        data_operandB = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (data_resultRDY) seen = 1'b1;
        end
        if (!seen) lat = 999;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(data_result), 64'(exp_r));
        check({tag, "_exc"}, 64'(data_exception), 64'(exp_e));
`ifdef MULTDIV_HI_EN
        check({tag, "_hi"}, 64'(data_resultHi), 64'(exp_hi));
`endif
        @(posedge clock);
        #1;
        check({tag, "_rdy_low"}, 64'(data_resultRDY), 64'(1'b0));
        check({tag, "_hold"}, 64'(data_result), 64'(exp_r));
    endtask

    initial begin
        logic [31:0] a, b, er, ehi, rr;
        logic        ee, re;
        int          elat, rdy_cnt, first;
        bit          is_m;

        tests         = 0;
        fails         = 0;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_res", 64'(data_result), 64'h0);
        check("reset_exc", 64'(data_exception), 64'h0);
        check("reset_rdy", 64'(data_resultRDY), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        // Directed cases with hand-derived expectations.
        run_op("mul_7xm3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32'hFFFF_FFFF, 16);
        run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 32'h1, 16);
        run_op("div_m7d2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32);
        run_op("div_zero", 0, 1, 32'd5, 32'd0, DBZ, 1'b1, 32'h0, 1);
        run_op("div_minm1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0, 32);
        run_op("mul_minmin", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 32'h4000_0000, 16);
        run_op("mul_m1m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 16);
        run_op("div_min1", 0, 1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 32'h0, 32);
        run_op("both_start", 1, 1, 32'd6, 32'd7, 32'd42, 1'b0, 32'h0, 16);

        // Randomized operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            a    = rand_operand();
            b    = rand_operand();
            is_m = (i % 2 == 0);
            ref_model(is_m, a, b, er, ee, ehi, elat);
            run_op($sformatf("rnd%0d_%s", i, is_m ? "mul" : "div"), is_m, !is_m, a, b, er, ee, ehi, elat);
        end

        // MULT started at edge k, restarted as DIV 100/10 at edge k+5:
        // exactly one RDY, just after edge k+37.
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = $urandom;
        data_operandB = $urandom;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        rdy_cnt   = 0;
        first     = -1;
        rr        = '0;
        re        = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                @(negedge clock);
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd10;
            end
            @(posedge clock);
            #1;
            if (i == 5) ctrl_DIV = 1'b0;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (first < 0) begin
                    first = i;
                    rr    = data_result;
                    re    = data_exception;
                end
            end
        end
        check("restart_rdy_count", 64'(rdy_cnt), 64'd1);
        check("restart_rdy_edge", 64'(first), 64'd37);
        check("restart_res", 64'(rr), 64'd10);
        check("restart_exc", 64'(re), 64'd0);

        // Reset asserted mid-DIV: outputs clear at once, no RDY afterwards.
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd12345;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_res", 64'(data_result), 64'h0);
        check("midrst_exc", 64'(data_exception), 64'h0);
        check("midrst_rdy", 64'(data_resultRDY), 64'h0);
`ifdef MULTDIV_HI_EN
        check("midrst_hi", 64'(data_resultHi), 64'h0);
`endif
        @(negedge clock);
        reset   = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        check("midrst_no_rdy", 64'(rdy_cnt), 64'd0);
        check("midrst_res_held", 64'(data_result), 64'h0);

        // Unit still works after the abort.
        run_op("post_rst_mul", 1, 0, 32'd1000, 32'hFFFF_FC18, 32'hFFF0_BDC0, 1'b0, 32'hFFFF_FFFF, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
